obj_detect_array: RTL and testbench
===================================

Name: obj_detect_array

Overview:
- Parametrised N-channel successor to the fixed L/R/F object detector.
- Each sensor input is synchronised, then debounced with a persistence filter.
- Outputs: per-channel detected flags, one-cycle rise/fall event strobes, an any-detected flag, a detected-channel count and a priority index.
- Sits between the raw proximity sensors and the steering/avoidance logic.
- Default configuration is 3 channels, bit order {L,R,F} = bits {2,1,0}.

Parameters:
- NUM_CH, 3: number of sensor channels (>=1).
- DEB_CYCLES, 4: consecutive synchronised samples of the opposite value needed before a flag toggles (>=1).
- CNT_W, $clog2(DEB_CYCLES+1): debounce counter width (derived).
- IDX_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1): width of pri_idx (derived).
- NUM_W, $clog2(NUM_CH+1): width of det_count (derived).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sens  input  NUM_CH  raw sensor inputs, asynchronous to clk.
- ch_en  input  NUM_CH  per-channel enable mask, synchronous to clk.
- clr_sticky  input  1  clears sticky flags (optional feature only).
- detected  output  NUM_CH  debounced detect flags, registered.
- rise_evt  output  NUM_CH  1-cycle pulse on detected 0->1.
- fall_evt  output  NUM_CH  1-cycle pulse on detected 1->0.
- any_det  output  1  OR of detected.
- det_count  output  NUM_W  number of set bits in detected.
- pri_idx  output  IDX_W  lowest index with detected=1; 0 when none.
- sticky  output  NUM_CH  latched rise history (optional feature only).

Behaviour:
- Reset (reset=0, asynchronous): all sync flops, counters, detected, rise_evt, fall_evt and sticky go to 0. Derived outputs are therefore any_det=0, det_count=0, pri_idx=0.
- Synchroniser: 2-flop chain per channel (s1<=sens, s2<=s1). The filter sees only s2.
- Filter, per channel i, on each rising edge:
  - ch_en[i]=0: cnt<=0. If detected[i]=1, then detected[i]<=0 and fall_evt[i]<=1 on this edge.
  - s2==detected[i]: cnt<=0.
  - otherwise, cnt<=cnt+1. When cnt==DEB_CYCLES-1: detected[i]<=~detected[i], cnt<=0, and the matching rise_evt[i] or fall_evt[i] is 1 for exactly this one cycle.
- Latency: a clean sens change captured into s1 at edge k appears on detected at edge k+DEB_CYCLES+1. With defaults this is 5 cycles.
- Glitches: if s2 returns to the detected value before DEB_CYCLES consecutive differing samples, the counter clears and there is no output change and no event.
- Event strobes are 0 in every cycle without a toggle. Rise and fall never both assert on the same channel in the same cycle.
- Counter never exceeds DEB_CYCLES-1; no wrap-around.
- any_det, det_count and pri_idx are combinational from the detected register, so they change in the same cycle as detected.
- pri_idx: channel 0 (F in default order) has the highest priority. When any_det=0, pri_idx=0 and is qualified by any_det.
- Channels are fully independent. Simultaneous toggles on several channels all occur in the same cycle.
- A channel re-enabled with s2=1 re-enters filtering from detected=0 and needs the full DEB_CYCLES again.
- Reset asserted mid-debounce discards all progress. After release, s1/s2 refill in 2 cycles, then normal filtering resumes.

Optional Feature:
- Macro: OBJ_DET_STICKY_EN.
- Defined:
  - sticky[i] is set on any edge where rise_evt[i] is being asserted.
  - clr_sticky=1 clears all sticky bits on the next edge.
  - Set and clear on the same edge: set wins for that channel.
  - Masking a channel does not clear sticky.
- Not defined: sticky is tied to 0 and clr_sticky is ignored. Ports remain present.

Test Plan (NUM_CH=3, DEB_CYCLES=4):
- Reset check: hold reset=0 with sens=3'b111 and ch_en=3'b111 -> all outputs 0. Release and keep sens=3'b111 -> detected=3'b111 five cycles after the first capture edge, rise_evt=3'b111 for one cycle, det_count=3, pri_idx=0.
- Glitch rejection: sens=3'b100 held 3 cycles then 3'b000 -> detected stays 000, no events. Holding 3'b100 -> detected=100 at latency 5, pri_idx=2, det_count=1.
- Priority and count: step sens 100 -> 110 -> 111 -> 011 with each step held 10 cycles -> pri_idx sequence 2, 1, 0, 0. det_count sequence 1, 2, 3, 2. fall_evt[2] pulses once on the last step.
- Mask: with detected=3'b111, drop ch_en to 3'b110 -> next edge detected=3'b110 and fall_evt=3'b001. Restore ch_en=3'b111 -> detected[0] returns after 4 cycles.
- Async reset mid-debounce: apply sens=001, then pulse reset low between clock edges 2 cycles into the count -> outputs clear immediately. After release, detection requires a full 2+4 cycles again.
- Sticky (macro defined): a rise on ch1, then clr_sticky on the same edge as a new rise on ch1 -> sticky[1] stays 1. A clr_sticky alone then clears sticky to 000.

Source files
------------

// File: rtl/obj_detect_array.sv
`default_nettype none
// obj_detect_array: N-channel synchronised, debounced object detector with events, count and priority index.
// Optional sticky rise history is enabled by defining OBJ_DET_STICKY_EN.
module obj_detect_array #(
  parameter int NUM_CH     = 3,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = $clog2(DEB_CYCLES + 1),
  parameter int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int NUM_W      = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sens,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              clr_sticky,
  output logic [NUM_CH-1:0] detected,
  output logic [NUM_CH-1:0] rise_evt,
  output logic [NUM_CH-1:0] fall_evt,
  output logic              any_det,
  output logic [NUM_W-1:0]  det_count,
  output logic [IDX_W-1:0]  pri_idx,
  output logic [NUM_CH-1:0] sticky
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_CH-1:0] s1_q, s2_q;
  logic [NUM_CH-1:0] det_q, det_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      det_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= sens;
      s2_q   <= s1_q;
      det_q  <= det_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Masking forces an immediate drop; otherwise a flag only toggles after
  // DEB_CYCLES consecutive synchronised samples disagree with it.
  always_comb begin
    det_d  = det_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!ch_en[i]) begin
        cnt_d[i] = '0;
        if (det_q[i]) begin
          det_d[i]  = 1'b0;
          fall_d[i] = 1'b1;
        end
      end else if (s2_q[i] == det_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        cnt_d[i] = '0;
        det_d[i] = ~det_q[i];
        if (det_q[i]) begin
          fall_d[i] = 1'b1;
        end else begin
          rise_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    det_count = '0;
    pri_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      det_count = det_count + NUM_W'(det_q[i]);
    end
    // Walk downward so the lowest set index is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (det_q[i]) begin
        pri_idx = IDX_W'(i);
      end
    end
  end

  assign detected = det_q;
  assign rise_evt = rise_q;
  assign fall_evt = fall_q;
  assign any_det  = |det_q;

`ifdef OBJ_DET_STICKY_EN
  logic [NUM_CH-1:0] sticky_q, sticky_d;

  // A rise on the same edge as a clear keeps that channel set.
  assign sticky_d = (clr_sticky ? '0 : sticky_q) | rise_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign sticky     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obj_detect_array.sv
`default_nettype none
// Self-checking bench for obj_detect_array (NUM_CH=3, DEB_CYCLES=4), scoreboard of expected output snapshots.
module tb_obj_detect_array;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sens;
  logic [2:0] ch_en;
  logic       clr_sticky;
  logic [2:0] detected, rise_evt, fall_evt, sticky;
  logic       any_det;
  logic [1:0] det_count, pri_idx;

  obj_detect_array #(.NUM_CH(3), .DEB_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sens       (sens),
    .ch_en      (ch_en),
    .clr_sticky (clr_sticky),
    .detected   (detected),
    .rise_evt   (rise_evt),
    .fall_evt   (fall_evt),
    .any_det    (any_det),
    .det_count  (det_count),
    .pri_idx    (pri_idx),
    .sticky     (sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] det;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       any;
    logic [1:0] cnt;
    logic [1:0] pri;
    logic [2:0] stk;
  } obs_t;

  obs_t w_obs;
  assign w_obs = {detected, rise_evt, fall_evt, any_det, det_count, pri_idx, sticky};

  obs_t       exp_q[$];
  obs_t       e;
  logic [2:0] stk_exp;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected snapshot after one edge; derived outputs come from the expected flags.
  function automatic obs_t mk_exp(input logic [2:0] det, input logic [2:0] rise,
                                  input logic [2:0] fall, input logic clr);
    obs_t       r;
    logic [1:0] p;
    p = 2'd0;
    for (int i = 2; i >= 0; i--) if (det[i]) p = 2'(i);
`ifdef OBJ_DET_STICKY_EN
    stk_exp = (clr ? 3'b000 : stk_exp) | rise;
`else
    stk_exp = 3'b000;
`endif
    r = {det, rise, fall, |det, 2'($countones(det)), p, stk_exp};
    return r;
  endfunction

  task automatic hold_reset(input logic [2:0] s);
    reset = 1'b0;
    sens  = s;
    tick();
    tick();
    reset   = 1'b1;
    stk_exp = 3'b000;
  endtask

  task automatic test_reset;
    reset = 1'b0; sens = 3'b111; ch_en = 3'b111; clr_sticky = 1'b0; stk_exp = 3'b000;
    for (int n = 1; n <= 3; n++) begin
      exp_q.push_back(mk_exp(3'b000, 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL reset_hold n=%0d got %b want %b", n, w_obs, e);
      end
    end
    reset = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      exp_q.push_back(mk_exp((n >= 6) ? 3'b111 : 3'b000, (n == 6) ? 3'b111 : 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL reset_release n=%0d got %b want %b", n, w_obs, e);
      end
    end
  endtask

  task automatic test_glitch;
    hold_reset(3'b000);
    for (int n = 1; n <= 12; n++) begin
      sens = (n <= 3) ? 3'b100 : 3'b000;
      exp_q.push_back(mk_exp(3'b000, 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL glitch n=%0d got %b want %b", n, w_obs, e);
      end
    end
    for (int n = 1; n <= 8; n++) begin
      sens = 3'b100;
      exp_q.push_back(mk_exp((n >= 6) ? 3'b100 : 3'b000, (n == 6) ? 3'b100 : 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL glitch_hold n=%0d got %b want %b", n, w_obs, e);
      end
    end
  endtask

  task automatic test_priority;
    logic [2:0] steps [3];
    logic [2:0] prev, cur;
    steps = '{3'b110, 3'b111, 3'b011};
    prev  = 3'b100;
    for (int s = 0; s < 3; s++) begin
      cur = steps[s];
      for (int n = 1; n <= 10; n++) begin
        sens = cur;
        if (n == 6) exp_q.push_back(mk_exp(cur, cur & ~prev, prev & ~cur, 1'b0));
        else        exp_q.push_back(mk_exp((n > 6) ? cur : prev, 3'b000, 3'b000, 1'b0));
        tick();
        e = exp_q.pop_front();
        n_vec++;
        if (w_obs !== e) begin
          n_err++;
          $display("FAIL priority step=%0d n=%0d got %b want %b", s, n, w_obs, e);
        end
      end
      prev = cur;
    end
  endtask

  task automatic test_mask;
    for (int n = 1; n <= 10; n++) begin
      sens = 3'b111;
      if (n == 6) exp_q.push_back(mk_exp(3'b111, 3'b100, 3'b000, 1'b0));
      else        exp_q.push_back(mk_exp((n > 6) ? 3'b111 : 3'b011, 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL mask_setup n=%0d got %b want %b", n, w_obs, e);
      end
    end
    for (int n = 1; n <= 9; n++) begin
      ch_en = (n <= 3) ? 3'b110 : 3'b111;
      if (n == 1)      exp_q.push_back(mk_exp(3'b110, 3'b000, 3'b001, 1'b0));
      else if (n == 7) exp_q.push_back(mk_exp(3'b111, 3'b001, 3'b000, 1'b0));
      else             exp_q.push_back(mk_exp((n > 7) ? 3'b111 : 3'b110, 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL mask n=%0d got %b want %b", n, w_obs, e);
      end
    end
  endtask

  task automatic test_async_reset;
    hold_reset(3'b100);
    for (int n = 1; n <= 8; n++) begin
      exp_q.push_back(mk_exp((n >= 6) ? 3'b100 : 3'b000, (n == 6) ? 3'b100 : 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL arst_setup n=%0d got %b want %b", n, w_obs, e);
      end
    end
    for (int n = 1; n <= 4; n++) begin
      sens = 3'b101;
      exp_q.push_back(mk_exp(3'b100, 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL arst_count n=%0d got %b want %b", n, w_obs, e);
      end
    end
    #3 reset = 1'b0;
    stk_exp = 3'b000;
    #1;
    exp_q.push_back(mk_exp(3'b000, 3'b000, 3'b000, 1'b0));
    e = exp_q.pop_front();
    n_vec++;
    if (w_obs !== e) begin
      n_err++;
      $display("FAIL arst_immediate got %b want %b", w_obs, e);
    end
    #2 reset = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      exp_q.push_back(mk_exp((n >= 6) ? 3'b101 : 3'b000, (n == 6) ? 3'b101 : 3'b000, 3'b000, 1'b0));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL arst_recover n=%0d got %b want %b", n, w_obs, e);
      end
    end
  endtask

  task automatic test_sticky;
    logic [2:0] steps [3];
    logic [2:0] prev, cur;
    steps = '{3'b010, 3'b000, 3'b010};
    prev  = 3'b000;
    hold_reset(3'b000);
    for (int s = 0; s < 3; s++) begin
      cur = steps[s];
      for (int n = 1; n <= 8; n++) begin
        sens       = cur;
        clr_sticky = (s == 2) && (n == 6);
        if (n == 6) exp_q.push_back(mk_exp(cur, cur & ~prev, prev & ~cur, clr_sticky));
        else        exp_q.push_back(mk_exp((n > 6) ? cur : prev, 3'b000, 3'b000, clr_sticky));
        tick();
        e = exp_q.pop_front();
        n_vec++;
        if (w_obs !== e) begin
          n_err++;
          $display("FAIL sticky step=%0d n=%0d got %b want %b", s, n, w_obs, e);
        end
      end
      clr_sticky = 1'b0;
      prev = cur;
    end
    for (int n = 1; n <= 2; n++) begin
      clr_sticky = (n == 1);
      exp_q.push_back(mk_exp(3'b010, 3'b000, 3'b000, clr_sticky));
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin
        n_err++;
        $display("FAIL sticky_clear n=%0d got %b want %b", n, w_obs, e);
      end
    end
    clr_sticky = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_priority();
    test_mask();
    test_async_reset();
    test_sticky();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
